ram_arbiter: RTL and testbench

Single-port data-RAM arbiter between the AVR core and one DMA-style requester (video line fetch, block copy). Owns the RAM address/data/write-enable bus and gives each cycle to exactly one side. Stalls the core through its clock-enable input when a cycle goes to DMA. Keeps the core's one-cycle read latency intact across stalls.

---
 rtl/ram_arbiter_if.sv | 28 ++
 rtl/ram_arbiter.sv | 45 ++++
 tb/tb_ram_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: core, DMA and RAM-side signals of the data-RAM arbiter.
interface ram_arbiter_if;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wb;
  logic        cpu_w;
  logic [7:0]  cpu_din;
  logic        cpu_ce;
  logic        dma_req;
  logic        dma_urgent;
  logic [15:0] dma_address;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic        dma_valid;
  logic [7:0]  dma_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  modport slave (
    input  cpu_address, cpu_wb, cpu_w, dma_req, dma_urgent, dma_address, dma_we, dma_wdata, ram_rdata,
    output cpu_din, cpu_ce, dma_ack, dma_valid, dma_rdata, ram_address, ram_wdata, ram_we
  );
  modport master (
    output cpu_address, cpu_wb, cpu_w, dma_req, dma_urgent, dma_address, dma_we, dma_wdata, ram_rdata,
    input  cpu_din, cpu_ce, dma_ack, dma_valid, dma_rdata, ram_address, ram_wdata, ram_we
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: gives each single-port data-RAM cycle to the AVR core or the DMA requester,
// stalling the core via cpu_ce and preserving its one-cycle read data across stalls.
module ram_arbiter #(
  parameter int CPU_BURST = 3
) (
  input logic clock,
  input logic reset,
  ram_arbiter_if.slave bus
);
  localparam int RW = CPU_BURST < 1 ? 1 : $clog2(CPU_BURST + 1);
  localparam logic [0:0] CPU = 1'b0;
  localparam logic [0:0] DMA = 1'b1;
  logic [0:0] grant, prev_grant;
  logic [RW-1:0] run;
  logic [7:0] hold;
  logic burst_done;
  logic [0:0] grant_next;
  // run holds the core cycles already granted under a pending request; the current one adds one more
  assign burst_done = (CPU_BURST == 0) ||
                      (grant == CPU && ({1'b0, run} + 1'b1) >= (RW + 1)'(CPU_BURST));
  assign grant_next = bus.dma_req && (bus.dma_urgent || burst_done) ? DMA : CPU;
  assign bus.ram_address = grant == DMA ? bus.dma_address : bus.cpu_address;
  assign bus.ram_wdata = grant == DMA ? bus.dma_wdata : bus.cpu_wb;
  assign bus.ram_we = grant == DMA ? bus.dma_we : bus.cpu_w;
  assign bus.cpu_ce = grant == CPU;
  assign bus.dma_ack = grant == DMA;
  assign bus.dma_rdata = bus.ram_rdata;
  // after a DMA cycle the RAM output belongs to DMA, so the core keeps seeing its own captured data
  assign bus.cpu_din = prev_grant == CPU ? bus.ram_rdata : hold;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant <= CPU;
      prev_grant <= CPU;
      run <= '0;
      hold <= '0;
      bus.dma_valid <= 1'b0;
    end else begin
      grant <= grant_next;
      prev_grant <= grant;
      run <= (grant == DMA || !bus.dma_req) ? '0 : run == RW'(CPU_BURST) ? run : run + 1'b1;
      hold <= prev_grant == CPU ? bus.ram_rdata : hold;
      bus.dma_valid <= grant == DMA && !bus.dma_we;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter (CPU_BURST=3 and CPU_BURST=0) against a read-first sync RAM.
module tb_ram_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:65535];
  ram_arbiter_if b3();
  ram_arbiter_if b0();
  ram_arbiter #(.CPU_BURST(3)) dut3 (.clock(clock), .reset(reset), .bus(b3));
  ram_arbiter #(.CPU_BURST(0)) dut0 (.clock(clock), .reset(reset), .bus(b0));
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (b3.ram_we) mem[b3.ram_address] <= b3.ram_wdata;
    b3.ram_rdata <= mem[b3.ram_address];
  end
  assign b0.ram_rdata = 8'h00;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    logic ae, ve;
    b3.cpu_address = '0; b3.cpu_wb = '0; b3.cpu_w = 1'b0;
    b3.dma_req = 1'b0; b3.dma_urgent = 1'b0; b3.dma_address = '0; b3.dma_we = 1'b0; b3.dma_wdata = '0;
    b0.cpu_address = '0; b0.cpu_wb = '0; b0.cpu_w = 1'b0;
    b0.dma_req = 1'b0; b0.dma_urgent = 1'b0; b0.dma_address = '0; b0.dma_we = 1'b0; b0.dma_wdata = '0;
    // preload RAM through the core path, which owns the bus during reset
    for (int i = 0; i < 8; i++) begin
      b3.cpu_address = 16'(16'h2000 + i);
      b3.cpu_wb = 8'(8'h30 + i);
      b3.cpu_w = 1'b1;
      tick;
    end
    b3.cpu_address = 16'h0200; b3.cpu_wb = 8'h11;
    tick;
    b3.cpu_w = 1'b0; b3.cpu_address = 16'h1234;
    #1;
    chk1("rst cpu_ce", b3.cpu_ce, 1'b1);
    chk1("rst dma_ack", b3.dma_ack, 1'b0);
    chk1("rst dma_valid", b3.dma_valid, 1'b0);
    chk("rst ram_address", b3.ram_address, 16'h1234);
    chk1("rst ram_we", b3.ram_we, 1'b0);
    chk1("rst0 cpu_ce", b0.cpu_ce, 1'b1);
    chk1("rst0 dma_ack", b0.dma_ack, 1'b0);
    reset = 1'b0;
    // core write then read with DMA idle
    tick;
    b3.cpu_address = 16'h0100; b3.cpu_wb = 8'h5A; b3.cpu_w = 1'b1;
    #1;
    chk1("wr ram_we", b3.ram_we, 1'b1);
    chk("wr ram_address", b3.ram_address, 16'h0100);
    chk("wr ram_wdata", 16'(b3.ram_wdata), 16'h005A);
    chk1("wr cpu_ce", b3.cpu_ce, 1'b1);
    tick;
    b3.cpu_w = 1'b0;
    #1;
    chk1("rd ram_we", b3.ram_we, 1'b0);
    chk1("rd cpu_ce", b3.cpu_ce, 1'b1);
    tick;
    #1;
    chk("rd cpu_din", 16'(b3.cpu_din), 16'h005A);
    chk1("rd cpu_ce2", b3.cpu_ce, 1'b1);
    // 8 non-urgent DMA reads: ack every 4th cycle, valid one cycle later
    k = 0;
    for (int c = 0; c < 36; c++) begin
      tick;
      ae = (c % 4 == 3) && c <= 31;
      ve = (c % 4 == 0) && c >= 4 && c <= 32;
      b3.dma_req = (k < 8) && !(b3.dma_ack && k == 7);
      b3.dma_address = 16'(16'h2000 + k);
      #1;
      chk1("burst dma_ack", b3.dma_ack, ae);
      chk1("burst cpu_ce", b3.cpu_ce, !ae);
      chk1("burst dma_valid", b3.dma_valid, ve);
      chk("burst cpu_din", 16'(b3.cpu_din), 16'h005A);
      if (ae) chk("burst ram_address", b3.ram_address, 16'(16'h2000 + c / 4));
      if (ve) chk("burst dma_rdata", 16'(b3.dma_rdata), 16'(16'h0030 + c / 4 - 1));
      if (b3.dma_ack) k++;
    end
    // request withdrawn before grant clears the run count
    for (int c = 0; c < 8; c++) begin
      tick;
      b3.dma_req = (c != 2) && !(c == 6);
      b3.dma_address = 16'h2004;
      #1;
      chk1("withdraw dma_ack", b3.dma_ack, c == 6);
      chk1("withdraw dma_valid", b3.dma_valid, c == 7);
    end
    chk("withdraw dma_rdata", 16'(b3.dma_rdata), 16'h0034);
    // urgent 4-word write burst
    tick;
    b3.dma_req = 1'b1; b3.dma_urgent = 1'b1; b3.dma_we = 1'b1;
    b3.dma_address = 16'h3000; b3.dma_wdata = 8'hA0;
    #1;
    chk1("urg pre ack", b3.dma_ack, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      b3.dma_address = 16'(16'h3000 + i);
      b3.dma_wdata = 8'(8'hA0 + i);
      b3.dma_req = (i != 3);
      #1;
      chk1("urg dma_ack", b3.dma_ack, 1'b1);
      chk1("urg cpu_ce", b3.cpu_ce, 1'b0);
      chk1("urg ram_we", b3.ram_we, 1'b1);
      chk("urg ram_address", b3.ram_address, 16'(16'h3000 + i));
      chk("urg cpu_din", 16'(b3.cpu_din), 16'h005A);
    end
    tick;
    b3.dma_urgent = 1'b0; b3.dma_we = 1'b0; b3.cpu_address = 16'h3002;
    #1;
    chk1("urg post ack", b3.dma_ack, 1'b0);
    chk1("urg post cpu_ce", b3.cpu_ce, 1'b1);
    chk1("urg post valid", b3.dma_valid, 1'b0);
    tick;
    #1;
    chk("urg readback", 16'(b3.cpu_din), 16'h00A2);
    // core read preserved across a DMA write to the same address
    tick;
    b3.cpu_address = 16'h0200;
    b3.dma_req = 1'b1; b3.dma_urgent = 1'b1; b3.dma_we = 1'b1;
    b3.dma_address = 16'h0200; b3.dma_wdata = 8'h22;
    #1;
    chk1("keep pre ack", b3.dma_ack, 1'b0);
    tick;
    b3.dma_req = 1'b0;
    #1;
    chk1("keep dma_ack", b3.dma_ack, 1'b1);
    chk1("keep ram_we", b3.ram_we, 1'b1);
    chk("keep ram_address", b3.ram_address, 16'h0200);
    tick;
    b3.dma_urgent = 1'b0; b3.dma_we = 1'b0;
    #1;
    chk1("keep cpu_ce", b3.cpu_ce, 1'b1);
    chk("keep old data", 16'(b3.cpu_din), 16'h0011);
    tick;
    #1;
    chk("keep new data", 16'(b3.cpu_din), 16'h0022);
    // asynchronous reset during an urgent read burst
    tick;
    b3.dma_req = 1'b1; b3.dma_urgent = 1'b1; b3.dma_address = 16'h2005;
    #1;
    chk1("rstb pre ack", b3.dma_ack, 1'b0);
    tick;
    #1;
    chk1("rstb ack", b3.dma_ack, 1'b1);
    reset = 1'b1;
    b3.dma_req = 1'b0; b3.dma_urgent = 1'b0;
    #1;
    chk1("rstb cpu_ce", b3.cpu_ce, 1'b1);
    chk1("rstb dma_ack", b3.dma_ack, 1'b0);
    chk("rstb ram_address", b3.ram_address, 16'h0200);
    tick;
    reset = 1'b0;
    #1;
    chk1("rstb valid0", b3.dma_valid, 1'b0);
    tick;
    #1;
    chk1("rstb valid1", b3.dma_valid, 1'b0);
    chk1("rstb ack1", b3.dma_ack, 1'b0);
    // CPU_BURST=0: DMA takes every requested cycle
    tick;
    b0.dma_req = 1'b1; b0.dma_address = 16'h0040;
    #1;
    chk1("b0 pre ack", b0.dma_ack, 1'b0);
    chk1("b0 pre cpu_ce", b0.cpu_ce, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick;
      b0.dma_req = (i != 3);
      #1;
      chk1("b0 dma_ack", b0.dma_ack, 1'b1);
      chk1("b0 cpu_ce", b0.cpu_ce, 1'b0);
      chk("b0 ram_address", b0.ram_address, 16'h0040);
    end
    tick;
    #1;
    chk1("b0 resume cpu_ce", b0.cpu_ce, 1'b1);
    chk1("b0 resume ack", b0.dma_ack, 1'b0);
    chk("b0 resume address", b0.ram_address, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
